// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Instruction-fetch front end. Generates the fetch address stream for a
// request/ready + rvalid instruction memory, keeps at most one request in
// flight, buffers a returned word while decode is stalled, and redirects
// fetch when EX resolves a taken branch, JAL or JALR.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   PCSrc[1:0]          next-PC select from EX (01 PCTarget, 10 ALUResult)
//   ResolveValid        PCSrc / PCTarget / ALUResult are meaningful
//   PCTarget[31:0]      PC + imm target
//   ALUResult[31:0]     JALR target before LSB clear
//   Stall               decode cannot take an instruction this cycle
//   imem_req/addr       fetch request and its address
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/rdata   returned instruction word (one per accepted request)
//   instr_valid         instr_out / pc_out valid to decode
//   instr_out, pc_out   fetched word and its address
//   flush_out           one-cycle pulse: kill younger instructions in IF/ID
//   fetch_fault         (only with PC_ALIGN_CHECK_EN) sticky misaligned-target
//
// Build option
//   PC_ALIGN_CHECK_EN   when defined, a redirect target with bits[1:0] != 0
//                       parks the sequencer in FAULT and raises fetch_fault.
//                       When undefined, target bits[1:0] are forced to 00.
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  PCSrc,
    input  logic        ResolveValid,
    input  logic [31:0] PCTarget,
    input  logic [31:0] ALUResult,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        flush_out
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t      state_reg;
    logic [31:0] fetch_pc_reg;   // address of the request in flight / next request
    logic        discard_reg;    // response of the in-flight request must be dropped
    logic [31:0] hold_buf_reg;   // word captured while decode stalls

    logic        redirect;
    logic [31:0] redirect_target;
    logic        present_now;
    logic        hold_present;

    // Target LSBs are either forced to zero or only inspected by the
    // alignment check; this keeps them formally consumed in both builds.
    logic        unused_target_lsbs;
    assign unused_target_lsbs = ^{ALUResult[1:0], PCTarget[1:0]};

    always_comb begin
        redirect = ResolveValid && ((PCSrc == 2'b01) || (PCSrc == 2'b10));
        if (PCSrc == 2'b10) begin
            redirect_target = {ALUResult[31:1], 1'b0};
        end else begin
            redirect_target = PCTarget;
        end
`ifndef PC_ALIGN_CHECK_EN
        redirect_target[1:0] = 2'b00;
`endif
    end

`ifdef PC_ALIGN_CHECK_EN
    logic target_misaligned;
    assign target_misaligned = (redirect_target[1:0] != 2'b00);
    assign fetch_fault       = (state_reg == ST_FAULT);
`endif

    // Outputs decode from state and current inputs: a returned word is
    // handed to decode in the rvalid cycle itself, and a redirect masks
    // instr_valid in the same cycle that flush_out pulses.
    always_comb begin
        present_now  = (state_reg == ST_WAIT) && imem_rvalid && !discard_reg
                       && !redirect && !Stall;
        hold_present = (state_reg == ST_HOLD) && !redirect;
        imem_req     = (state_reg == ST_REQ);
        imem_addr    = fetch_pc_reg;
        instr_valid  = present_now || hold_present;
        instr_out    = present_now  ? imem_rdata   :
                       hold_present ? hold_buf_reg : 32'h0;
        pc_out       = instr_valid ? fetch_pc_reg : 32'h0;
        flush_out    = rst_n && redirect;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_BOOT;
            fetch_pc_reg <= RESET_PC;
            discard_reg  <= 1'b0;
            hold_buf_reg <= 32'h0;
        end else if (redirect && (state_reg != ST_FAULT)) begin
            // Redirect wins over Stall; a later redirect simply overwrites
            // fetch_pc, so the newest target is the one fetched.
            hold_buf_reg <= 32'h0;
`ifdef PC_ALIGN_CHECK_EN
            if (target_misaligned) begin
                state_reg   <= ST_FAULT;
                discard_reg <= 1'b0;
            end else
`endif
            begin
                fetch_pc_reg <= redirect_target;
                case (state_reg)
                    ST_REQ: begin
                        // Not accepted: the address may still change.
                        // Accepted: the old word is on its way, drop it.
                        if (imem_ready) begin
                            state_reg   <= ST_WAIT;
                            discard_reg <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_rvalid) begin
                            state_reg   <= ST_REQ;
                            discard_reg <= 1'b0;
                        end else begin
                            discard_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg   <= ST_REQ;
                        discard_reg <= 1'b0;
                    end
                endcase
            end
        end else begin
            case (state_reg)
                ST_BOOT: begin
                    state_reg    <= ST_REQ;
                    fetch_pc_reg <= RESET_PC;
                end
                ST_REQ: begin
                    if (imem_ready) begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_reg) begin
                            discard_reg <= 1'b0;
                            state_reg   <= ST_REQ;
                        end else if (Stall) begin
                            hold_buf_reg <= imem_rdata;
                            state_reg    <= ST_HOLD;
                        end else begin
                            fetch_pc_reg <= fetch_pc_reg + 32'd4;
                            state_reg    <= ST_REQ;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!Stall) begin
                        fetch_pc_reg <= fetch_pc_reg + 32'd4;
                        hold_buf_reg <= 32'h0;
                        state_reg    <= ST_REQ;
                    end
                end
                ST_FAULT: begin
                    state_reg <= ST_FAULT;
                end
                default: begin
                    state_reg <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_fetch_sequencer.md
PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 PCSrc  in  2  next-PC select from EX: 00 = PC+4, 01 = PCTarget (branch/JAL), 10 = ALUResult (JALR), 11 = reserved.
REQ-005 ResolveValid  in  1  PCSrc/PCTarget/ALUResult valid this cycle.
REQ-006 PCTarget  in  32  PC+imm target.
REQ-007 ALUResult  in  32  JALR target before LSB clear.
REQ-008 Stall  in  1  decode cannot accept an instruction this cycle.
REQ-009 imem_req  out  1  fetch request valid.
REQ-010 imem_addr  out  32  fetch address, stable while imem_req && !imem_ready.
REQ-011 imem_ready  in  1  memory accepts the request this cycle.
REQ-012 imem_rvalid  in  1  read data returned (one per accepted request, latency >= 1).
REQ-013 imem_rdata  in  32  instruction word.
REQ-014 instr_valid  out  1  instr_out/pc_out valid to decode.
REQ-015 instr_out  out  32  fetched instruction.
REQ-016 pc_out  out  32  address of instr_out.
REQ-017 flush_out  out  1  one-cycle pulse: kill younger instructions in IF/ID.

Function
REQ-018 States SHALL be BOOT, REQ, WAIT, HOLD (plus FAULT, see Configuration); at most one request outstanding.
REQ-019 BOOT: imem_req=0; next cycle -> REQ with fetch_pc = RESET_PC.
REQ-020 REQ: imem_req=1, imem_addr=fetch_pc; on imem_ready -> WAIT.
REQ-021 WAIT: on imem_rvalid, if Stall=0 present word (instr_valid=1 for that cycle, pc_out = address of that request), fetch_pc += 4 modulo 2^32, -> REQ; if Stall=1 latch word into hold buffer -> HOLD.
REQ-022 HOLD: instr_valid=1 with buffered word; on Stall=0 fetch_pc += 4, -> REQ; buffered word SHALL not change while held.
REQ-023 Redirect = ResolveValid && (PCSrc==01 || PCSrc==10); PCSrc 00 or 11 SHALL not redirect.
REQ-024 Redirect target: 01 -> PCTarget; 10 -> {ALUResult[31:1],1'b0}.
REQ-025 Redirect SHALL assert flush_out the same cycle (combinational from inputs) for exactly one cycle, and set fetch_pc = target next cycle.
REQ-026 Redirect in REQ without imem_ready: next cycle imem_addr = target (address change permitted only because request not accepted).
REQ-027 Redirect in REQ with imem_ready, or in WAIT before rvalid: set discard flag; returned word SHALL be dropped (instr_valid=0), then -> REQ at target.
REQ-028 Redirect coincident with imem_rvalid in WAIT: word dropped, -> REQ at target.
REQ-029 Redirect in HOLD: buffer cleared, instr_valid=0 next cycle, -> REQ at target regardless of Stall.
REQ-030 Redirect has priority over Stall; a second redirect before fetch resumes SHALL overwrite the pending target.
REQ-031 instr_valid SHALL be 0 in the cycle flush_out=1.

Reset
REQ-032 rst_n low SHALL immediately force: state=BOOT, fetch_pc=RESET_PC, discard=0, hold buffer=0, imem_req=0, instr_valid=0, instr_out=0, pc_out=0, flush_out=0 (flush_out=0 while rst_n low regardless of inputs).
REQ-033 Reset mid-WAIT: the pending response after reset release SHALL be ignored (imem_rvalid outside WAIT is discarded).

Configuration
REQ-034 Macro PC_ALIGN_CHECK_EN: when defined, a redirect target with bits[1:0] != 00 SHALL enter FAULT (imem_req=0, instr_valid=0, output port fetch_fault=1 sticky until reset); when undefined, bits[1:0] SHALL be forced to 00 and fetch_fault port is absent.

Verification
REQ-035 Reset release, imem_ready=1, rvalid latency 1 -> imem_addr 0x0, 0x4, 0x8; pc_out matches each word.
REQ-036 rvalid with Stall=1 for 3 cycles, data 0x00500093 -> instr_valid held 3+ cycles, instr_out constant, next req at PC+4 after Stall drops.
REQ-037 ResolveValid, PCSrc=01, PCTarget=0x100 while in WAIT -> flush_out one cycle, returned word dropped, next imem_addr=0x100.
REQ-038 PCSrc=10, ALUResult=0x201 -> next imem_addr=0x200 (macro off); macro on with ALUResult=0x202 -> fetch_fault=1, imem_req=0.
REQ-039 PCSrc=11 with ResolveValid -> no flush, sequential fetch continues.
REQ-040 rst_n asserted during WAIT, rvalid arrives after release -> ignored, first address RESET_PC.
